// File: rtl/pipe_pkg.sv
// pipe_pkg: shared run-state encoding and default counter width for the pipeline controller
package pipe_pkg;
  typedef enum logic [1:0] {INIT, RUN, DRAIN, HALTED} pipe_state_e;
  localparam int CNT_W_DEF = 32;
endpackage

// File: rtl/perf_counter.sv
// perf_counter: wrapping event counter, increments on the edge where inc_i is high
// Ports: clk_i clock; rst_n_i async active-low reset; inc_i count enable; cnt_o count (wraps modulo 2^W)
module perf_counter #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) cnt_o <= '0;
    else cnt_o <= cnt_o + W'(inc_i);
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: turns hazard stall/flush into pipeline enables/clears, tracks stage valids, sequences run state
// Ports: clk_i/rst_n_i clock and async active-low reset; stall_f_i/stall_d_i/flush_d_i/flush_e_i hazard controls;
//   fetch_valid_i imem word valid; halt_req_i level halt request; resume_i pulse to leave HALTED;
//   en_f_o/en_d_o/clr_d_o/clr_e_o register enables/clears; valid_*_o stage valids; retire_o W retires;
//   halted_o in HALTED; cycle/instret/stall/flush_cnt_o wrapping perf counters
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int INIT_CYCLES = 4,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             stall_f_i,
  input  logic             stall_d_i,
  input  logic             flush_d_i,
  input  logic             flush_e_i,
  input  logic             fetch_valid_i,
  input  logic             halt_req_i,
  input  logic             resume_i,
  output logic             en_f_o,
  output logic             en_d_o,
  output logic             clr_d_o,
  output logic             clr_e_o,
  output logic             valid_d_o,
  output logic             valid_e_o,
  output logic             valid_m_o,
  output logic             valid_w_o,
  output logic             retire_o,
  output logic             halted_o,
  output logic [CNT_W-1:0] cycle_cnt_o,
  output logic [CNT_W-1:0] instret_cnt_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);
  localparam int IW = $clog2(INIT_CYCLES + 1);
  pipe_state_e   state, state_nxt;
  logic [IW-1:0] init_cnt;
  logic          issue;
  assign issue    = (state == RUN) && fetch_valid_i && !stall_f_i;
  // a flush redirect must load the PC even while draining
  assign en_f_o   = ((state == RUN) && !stall_f_i) || flush_d_i;
  assign en_d_o   = !stall_d_i;
  assign clr_d_o  = flush_d_i;
  assign clr_e_o  = flush_e_i;
  assign retire_o = valid_w_o;
  assign halted_o = state == HALTED;
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      state     <= INIT;
      init_cnt  <= '0;
      valid_d_o <= 1'b0;
      valid_e_o <= 1'b0;
      valid_m_o <= 1'b0;
      valid_w_o <= 1'b0;
    end else begin
      state     <= state_nxt;
      init_cnt  <= (state == INIT) ? init_cnt + IW'(1) : init_cnt;
      valid_d_o <= flush_d_i ? 1'b0 : stall_d_i ? valid_d_o : issue;
      valid_e_o <= flush_e_i ? 1'b0 : valid_d_o;
      valid_m_o <= valid_e_o;
      valid_w_o <= valid_m_o;
    end
  always_comb begin
    state_nxt = state;
    unique case (state)
      INIT:    state_nxt = (init_cnt == IW'(INIT_CYCLES - 1)) ? RUN : INIT;
      RUN:     state_nxt = halt_req_i ? DRAIN : RUN;
      DRAIN:   state_nxt = (valid_d_o || valid_e_o || valid_m_o || valid_w_o) ? DRAIN : HALTED;
      HALTED:  state_nxt = (resume_i && !halt_req_i) ? RUN : HALTED;
      default: state_nxt = INIT;
    endcase
  end
  perf_counter #(.W(CNT_W)) u_cycle (.clk_i(clk_i), .rst_n_i(rst_n_i), .inc_i(1'b1), .cnt_o(cycle_cnt_o));
  perf_counter #(.W(CNT_W)) u_instret (.clk_i(clk_i), .rst_n_i(rst_n_i), .inc_i(valid_w_o), .cnt_o(instret_cnt_o));
  perf_counter #(.W(CNT_W)) u_stall (.clk_i(clk_i), .rst_n_i(rst_n_i), .inc_i(stall_d_i && state != INIT), .cnt_o(stall_cnt_o));
  perf_counter #(.W(CNT_W)) u_flush (.clk_i(clk_i), .rst_n_i(rst_n_i), .inc_i(flush_d_i), .cnt_o(flush_cnt_o));
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed self-checking bench for pipe_ctrl, plus a 4-bit-counter instance for wrap behaviour
module tb_pipe_ctrl;
  logic clk = 0, rst_n = 0;
  logic stall_f = 0, stall_d = 0, flush_d = 0, flush_e = 0, fetch_valid = 1, halt_req = 0, resume = 0;
  logic en_f, en_d, clr_d, clr_e, vd, ve, vm, vw, retire, halted;
  logic [31:0] cycle_cnt, instret_cnt, stall_cnt, flush_cnt;
  logic en_f4, en_d4, clr_d4, clr_e4, vd4, ve4, vm4, vw4, retire4, halted4;
  logic [3:0] cycle4, instret4, stall4, flush4;
  int checks = 0, failures = 0, cyc = 0;
  always #5 clk = ~clk;
  pipe_ctrl dut (
    .clk_i(clk), .rst_n_i(rst_n), .stall_f_i(stall_f), .stall_d_i(stall_d), .flush_d_i(flush_d),
    .flush_e_i(flush_e), .fetch_valid_i(fetch_valid), .halt_req_i(halt_req), .resume_i(resume),
    .en_f_o(en_f), .en_d_o(en_d), .clr_d_o(clr_d), .clr_e_o(clr_e), .valid_d_o(vd), .valid_e_o(ve),
    .valid_m_o(vm), .valid_w_o(vw), .retire_o(retire), .halted_o(halted), .cycle_cnt_o(cycle_cnt),
    .instret_cnt_o(instret_cnt), .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
  );
  pipe_ctrl #(.CNT_W(4)) dut4 (
    .clk_i(clk), .rst_n_i(rst_n), .stall_f_i(stall_f), .stall_d_i(stall_d), .flush_d_i(flush_d),
    .flush_e_i(flush_e), .fetch_valid_i(fetch_valid), .halt_req_i(halt_req), .resume_i(resume),
    .en_f_o(en_f4), .en_d_o(en_d4), .clr_d_o(clr_d4), .clr_e_o(clr_e4), .valid_d_o(vd4), .valid_e_o(ve4),
    .valid_m_o(vm4), .valid_w_o(vw4), .retire_o(retire4), .halted_o(halted4), .cycle_cnt_o(cycle4),
    .instret_cnt_o(instret4), .stall_cnt_o(stall4), .flush_cnt_o(flush4)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic to(input int n);
    while (cyc < n) tick();
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valids", {vd, ve, vm, vw}, 0);
    chk("rst_retire", retire, 0);
    chk("rst_halted", halted, 0);
    chk("rst_cycle", cycle_cnt, 0);
    chk("rst_en_f", en_f, 0);
    rst_n = 1;
    stall_d = 1;
    #1;
    chk("init_en_d_stall", en_d, 0);
    chk("init_en_f0", en_f, 0);
    tick();
    stall_d = 0;
    #1;
    chk("init_stall_not_counted", stall_cnt, 0);
    chk("cycle_cnt1", cycle_cnt, 1);
    for (int c = 1; c < 4; c++) begin
      chk("init_en_f", en_f, 0);
      tick();
    end
    chk("run_en_f", en_f, 1);
    chk("run_vd4", vd, 0);
    to(5);  chk("first_vd", vd, 1);
    to(7);  chk("no_retire7", retire, 0);
    to(8);  chk("first_retire", retire, 1);
    chk("instret8", instret_cnt, 0);
    to(15); chk("c4_cycle15", cycle4, 15);
    to(16); chk("c4_cycle_wrap", cycle4, 0);
    chk("cycle16", cycle_cnt, 16);
    to(23); chk("c4_instret15", instret4, 15);
    to(24); chk("c4_instret_wrap", instret4, 0);
    chk("instret24", instret_cnt, 16);
    to(25);
    stall_f = 1; stall_d = 1; flush_e = 1;
    #1;
    chk("lu_en_f", en_f, 0);
    chk("lu_en_d", en_d, 0);
    chk("lu_clr_e", clr_e, 1);
    chk("lu_clr_d", clr_d, 0);
    tick();
    stall_f = 0; stall_d = 0; flush_e = 0;
    #1;
    chk("lu_vd_held", vd, 1);
    chk("lu_ve_bubble", ve, 0);
    chk("lu_stall_cnt", stall_cnt, 1);
    to(27); chk("lu_retire27", retire, 1);
    to(28); chk("lu_bubble_w", retire, 0);
    to(29); chk("lu_retire29", retire, 1);
    chk("instret29", instret_cnt, 20);
    chk("c4_instret29", instret4, 4);
    to(30);
    stall_f = 1; stall_d = 1; flush_d = 1; flush_e = 1;
    #1;
    chk("br_en_f", en_f, 1);
    chk("br_clr_d", clr_d, 1);
    tick();
    stall_f = 0; stall_d = 0; flush_d = 0; flush_e = 0;
    #1;
    chk("br_vd", vd, 0);
    chk("br_ve", ve, 0);
    chk("br_flush_cnt", flush_cnt, 1);
    chk("br_stall_cnt", stall_cnt, 2);
    to(32); chk("br_retire32", retire, 1);
    to(33); chk("br_gap33", retire, 0);
    to(34); chk("br_gap34", retire, 0);
    to(35); chk("br_retire35", retire, 1);
    to(40);
    halt_req = 1;
    #1;
    chk("halt_req_run_en_f", en_f, 1);
    tick();
    halt_req = 0;
    #1;
    chk("drain_en_f", en_f, 0);
    chk("drain_full", {vd, ve, vm, vw}, 4'hf);
    chk("drain_halted41", halted, 0);
    to(44); chk("drain_retire44", retire, 1);
    to(45); chk("drain_empty_retire", retire, 0);
    chk("drain_halted45", halted, 0);
    to(46); chk("halted46", halted, 1);
    chk("instret46", instret_cnt, 34);
    resume = 1; halt_req = 1;
    tick();
    #1;
    chk("resume_blocked", halted, 1);
    halt_req = 0;
    tick();
    resume = 0;
    #1;
    chk("resumed_halted", halted, 0);
    chk("resumed_en_f", en_f, 1);
    to(49); chk("resumed_vd", vd, 1);
    to(53);
    halt_req = 1;
    tick();
    halt_req = 0;
    #1;
    chk("pre_rst_full", {vd, ve, vm, vw}, 4'hf);
    chk("pre_rst_cycle", cycle_cnt, 54);
    #2;
    rst_n = 0;
    #1;
    chk("mid_rst_valids", {vd, ve, vm, vw}, 0);
    chk("mid_rst_instret", instret_cnt, 0);
    chk("mid_rst_cycle", cycle_cnt, 0);
    chk("mid_rst_flush", flush_cnt, 0);
    chk("mid_rst_en_f", en_f, 0);
    tick();
    chk("held_rst_retire", retire, 0);
    chk("held_rst_instret", instret_cnt, 0);
    rst_n = 1;
    cyc = 0;
    #1;
    chk("rerst_init_en_f", en_f, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
